pkt_rr_arbiter: RTL and testbench



---
 rtl/pkt_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_pkt_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: packet-granularity round-robin arbiter.
//
// Shares one byte-stream packet port (data/len/last/valid) between CH_NUM sources.
// A grant is held from arbitration until the granted source's last beat, or until
// it stays silent for TIMEOUT cycles, in which case the packet is aborted. Each
// packet is followed by one GAP cycle and one IDLE arbitration cycle. New grants are
// withheld while the downstream buffer reports almost-full.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_req           per-source request (source holds a complete packet)
//   o_grant         one-hot grant
//   i_data, i_len   per-source data / packet length, channel k at [k*W +: W]
//   i_last, i_valid per-source last flag (qualified by valid) and byte valid
//   i_dst_afull     downstream almost full, blocks new grants only
//   o_data, o_len, o_last, o_valid  arbitrated stream, registered (1-cycle latency)
//   o_ch            index of the granted channel
//   o_abort         one-cycle pulse on timeout abort
module pkt_rr_arbiter #(
  parameter int unsigned CH_NUM  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [CH_NUM-1:0]           i_req,
  output logic [CH_NUM-1:0]           o_grant,
  input  logic [CH_NUM*DATA_W-1:0]    i_data,
  input  logic [CH_NUM*LEN_W-1:0]     i_len,
  input  logic [CH_NUM-1:0]           i_last,
  input  logic [CH_NUM-1:0]           i_valid,
  input  logic                        i_dst_afull,
  output logic [DATA_W-1:0]           o_data,
  output logic [LEN_W-1:0]            o_len,
  output logic                        o_last,
  output logic                        o_valid,
  output logic [$clog2(CH_NUM)-1:0]   o_ch,
  output logic                        o_abort
);

  localparam int unsigned CH_W  = $clog2(CH_NUM);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

  state_e              state_q, state_d;
  logic [CH_NUM-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     last_ch_q, last_ch_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
  logic                abort_q, abort_d;

  logic [DATA_W-1:0]   sel_data;
  logic [LEN_W-1:0]    sel_len;
  logic                sel_last;
  logic                sel_valid;

  logic                win_found;
  logic [CH_W-1:0]     win_ch;

  // Only the granted channel is observed; everything else is ignored.
  always_comb begin
    sel_data  = '0;
    sel_len   = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (ch_q == CH_W'(k)) begin
        sel_data  = i_data[k*DATA_W +: DATA_W];
        sel_len   = i_len[k*LEN_W +: LEN_W];
        sel_last  = i_last[k];
        sel_valid = i_valid[k];
      end
    end
  end

  // First requester searching cyclically from last_ch+1.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (!win_found && i_req[(32'(last_ch_q) + i + 1) % CH_NUM]) begin
        win_found = 1'b1;
        win_ch    = CH_W'((32'(last_ch_q) + i + 1) % CH_NUM);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ch_d      = ch_q;
    last_ch_d = last_ch_q;
    cnt_d     = cnt_q;
    data_d    = '0;
    len_d     = len_q;
    last_d    = 1'b0;
    valid_d   = 1'b0;
    abort_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found && !i_dst_afull) begin
          grant_d = CH_NUM'(1) << win_ch;
          ch_d    = win_ch;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        valid_d = sel_valid;
        last_d  = sel_valid & sel_last;
        if (sel_valid) begin
          data_d = sel_data;
          len_d  = sel_len;
          cnt_d  = '0;
          if (sel_last) begin
            grant_d   = '0;
            last_ch_d = ch_q;
            state_d   = StGap;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This idle cycle makes the count reach TIMEOUT: drop the packet.
          grant_d   = '0;
          abort_d   = 1'b1;
          last_ch_d = ch_q;
          cnt_d     = '0;
          state_d   = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ch_q      <= '0;
      last_ch_q <= CH_W'(CH_NUM - 1);
      cnt_q     <= '0;
      data_q    <= '0;
      len_q     <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ch_q      <= ch_d;
      last_ch_q <= last_ch_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      len_q     <= len_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      abort_q   <= abort_d;
    end
  end

  assign o_grant = grant_q;
  assign o_ch    = ch_q;
  assign o_data  = data_q;
  assign o_len   = len_q;
  assign o_last  = last_q;
  assign o_valid = valid_q;
  assign o_abort = abort_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Testbench for pkt_rr_arbiter (CH_NUM=4, DATA_W=8, LEN_W=8, TIMEOUT=8).
module tb_pkt_rr_arbiter;

  localparam int unsigned CH_NUM  = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned TIMEOUT = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_req, i_last, i_valid;
  logic [31:0] i_data, i_len;
  logic        i_dst_afull;
  logic [3:0]  o_grant;
  logic [7:0]  o_data, o_len;
  logic        o_last, o_valid, o_abort;
  logic [1:0]  o_ch;

  always #5 i_clk = ~i_clk;

  pkt_rr_arbiter #(
    .CH_NUM (CH_NUM),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .o_grant    (o_grant),
    .i_data     (i_data),
    .i_len      (i_len),
    .i_last     (i_last),
    .i_valid    (i_valid),
    .i_dst_afull(i_dst_afull),
    .o_data     (o_data),
    .o_len      (o_len),
    .o_last     (o_last),
    .o_valid    (o_valid),
    .o_ch       (o_ch),
    .o_abort    (o_abort)
  );

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] ch;
    logic       valid;
    logic [7:0] data;
    logic [7:0] len;
    logic       last;
    logic       abort;
  } out_t;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [31:0] len;
    logic        afull;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic out_t mk(input logic [3:0] g, input logic [1:0] c, input logic v,
                              input logic [7:0] d, input logic [7:0] l, input logic la,
                              input logic ab);
    out_t o;
    o.grant = g; o.ch = c; o.valid = v; o.data = d; o.len = l; o.last = la; o.abort = ab;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t got;
    got = {o_grant, o_ch, o_valid, o_data, o_len, o_last, o_abort};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got grant=%b ch=%0d valid=%b data=%h len=%h last=%b abort=%b, expected grant=%b ch=%0d valid=%b data=%h len=%h last=%b abort=%b",
               name, $time, got.grant, got.ch, got.valid, got.data, got.len, got.last,
               got.abort, exp.grant, exp.ch, exp.valid, exp.data, exp.len, exp.last,
               exp.abort);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] valid, input logic [3:0] last,
                     input logic [31:0] data, input logic [31:0] len, input logic afull,
                     input out_t exp);
    vec_t v;
    v.req = req; v.valid = valid; v.last = last; v.data = data; v.len = len;
    v.afull = afull; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic clear_inputs();
    i_req = '0; i_valid = '0; i_last = '0; i_data = '0; i_len = '0; i_dst_afull = 1'b0;
  endtask

  task automatic edge_check(input string name, input out_t exp);
    @(posedge i_clk);
    #1;
    check(name, exp);
  endtask

  // Reference model: who owns the port, how many edges must pass before the next
  // arbitration, and how long the owner has been silent.
  int   m_owner, m_rr, m_skip, m_idle;
  out_t m_exp;

  function automatic void model_reset();
    m_owner = -1; m_rr = CH_NUM - 1; m_skip = 0; m_idle = 0; m_exp = '0;
  endfunction

  function automatic void model_step();
    bit found;
    int c;
    m_exp.valid = 1'b0; m_exp.last = 1'b0; m_exp.data = '0; m_exp.abort = 1'b0;
    if (m_owner >= 0) begin
      if (i_valid[m_owner]) begin
        m_exp.valid = 1'b1;
        m_exp.data  = i_data[m_owner*DATA_W +: DATA_W];
        m_exp.len   = i_len[m_owner*LEN_W +: LEN_W];
        m_idle = 0;
        if (i_last[m_owner]) begin
          m_exp.last = 1'b1; m_rr = m_owner; m_owner = -1; m_skip = 1;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_exp.abort = 1'b1; m_rr = m_owner; m_owner = -1; m_skip = 1; m_idle = 0;
        end
      end
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (i_req != 0 && !i_dst_afull) begin
      found = 1'b0;
      for (int i = 1; i <= CH_NUM; i++) begin
        c = (m_rr + i) % CH_NUM;
        if (!found && i_req[c]) begin
          found = 1'b1; m_owner = c;
        end
      end
      m_exp.ch = 2'(m_owner);
      m_idle = 0;
    end
    m_exp.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
  endfunction

  task automatic tick(input string name);
    model_step();
    @(posedge i_clk);
    #1;
    check(name, m_exp);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_state", mk(4'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_rr();
    int         beat[4];
    int         order[5];
    int         n;
    logic [3:0] prev;
    order = '{0, 1, 2, 3, 0};
    beat  = '{0, 0, 0, 0};
    n     = 0;
    prev  = '0;
    i_req = 4'hF;
    for (int cyc = 0; cyc < 60 && n < 5; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (m_exp.grant[c]) begin
          i_valid[c] = 1'b1;
          i_last[c]  = (beat[c] == 1);
          i_data[c*8 +: 8] = 8'(c * 16 + beat[c]);
          i_len[c*8 +: 8]  = 8'd2;
          beat[c]++;
        end else begin
          beat[c]    = 0;
          i_valid[c] = 1'($urandom);
          i_last[c]  = 1'($urandom);
          i_data[c*8 +: 8] = 8'($urandom);
          i_len[c*8 +: 8]  = 8'($urandom);
        end
      end
      tick("rr_stream");
      if (o_grant != 4'b0 && prev == 4'b0) begin
        vectors++;
        if (o_ch !== 2'(order[n])) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: got ch=%0d, expected ch=%0d", n, o_ch, order[n]);
        end
        n++;
      end
      prev = o_grant;
    end
    if (n < 5) begin
      vectors++;
      miscompares++;
      $display("FAIL rr_budget: got %0d grants, expected 5", n);
    end
  endtask

  task automatic run_random(input int cycles, input int pv, input int pl, input int pa,
                            input int prst);
    for (int n = 0; n < cycles; n++) begin
      i_req = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        i_valid[c] = (($urandom % 100) < pv);
        i_last[c]  = (($urandom % 100) < pl);
      end
      i_data      = $urandom;
      i_len       = $urandom;
      i_dst_afull = (($urandom % 100) < pa);
      if (($urandom % 1000) < prst) begin
        i_rst_n = 1'b0;
        #1;
        check("rand_async_reset", mk(4'b0, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        model_reset();
      end else begin
        tick("random");
      end
    end
  endtask

  initial begin
    clear_inputs();

    // ch1 4-byte packet; other channels' valid/last ignored; req drop and afull ignored.
    add(4'b0010, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b0010, 2'd1, 0, 8'h00, 8'h00, 0, 0));
    add(4'b0010, 4'b0010, 4'b0000, 32'h0000A000, 32'h00000400, 1'b0,
        mk(4'b0010, 2'd1, 1, 8'hA0, 8'h04, 0, 0));
    add(4'b0010, 4'b0011, 4'b0001, 32'h0000A155, 32'h00000409, 1'b0,
        mk(4'b0010, 2'd1, 1, 8'hA1, 8'h04, 0, 0));
    add(4'b0000, 4'b0010, 4'b0000, 32'h0000A200, 32'h00000400, 1'b1,
        mk(4'b0010, 2'd1, 1, 8'hA2, 8'h04, 0, 0));
    add(4'b0000, 4'b0010, 4'b0010, 32'h0000A300, 32'h00000400, 1'b0,
        mk(4'b0000, 2'd1, 1, 8'hA3, 8'h04, 1, 0));
    add(4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b0000, 2'd1, 0, 8'h00, 8'h04, 0, 0));
    add(4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b0000, 2'd1, 0, 8'h00, 8'h04, 0, 0));
    // ch3 1-byte packet, then ch0 granted two edges after ch3's last.
    add(4'b1000, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b1000, 2'd3, 0, 8'h00, 8'h04, 0, 0));
    add(4'b1001, 4'b1000, 4'b1000, 32'h77000000, 32'h01000000, 1'b0,
        mk(4'b0000, 2'd3, 1, 8'h77, 8'h01, 1, 0));
    add(4'b0001, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b0000, 2'd3, 0, 8'h00, 8'h01, 0, 0));
    add(4'b0001, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b0001, 2'd0, 0, 8'h00, 8'h01, 0, 0));
    add(4'b0001, 4'b0001, 4'b0001, 32'h00000011, 32'h00000001, 1'b0,
        mk(4'b0000, 2'd0, 1, 8'h11, 8'h01, 1, 0));
    add(4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b0000, 2'd0, 0, 8'h00, 8'h01, 0, 0));
    // afull blocks ch2 for three edges; afull mid-packet does not stall it.
    for (int k = 0; k < 3; k++)
      add(4'b0100, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b1, mk(4'b0000, 2'd0, 0, 8'h00, 8'h01, 0, 0));
    add(4'b0100, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b0100, 2'd2, 0, 8'h00, 8'h01, 0, 0));
    add(4'b0100, 4'b0100, 4'b0000, 32'h00210000, 32'h00020000, 1'b1,
        mk(4'b0100, 2'd2, 1, 8'h21, 8'h02, 0, 0));
    add(4'b0100, 4'b0100, 4'b0100, 32'h00220000, 32'h00020000, 1'b1,
        mk(4'b0000, 2'd2, 1, 8'h22, 8'h02, 1, 0));
    add(4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b0000, 2'd2, 0, 8'h00, 8'h02, 0, 0));
    add(4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0, 1'b0, mk(4'b0000, 2'd2, 0, 8'h00, 8'h02, 0, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      i_req = tbl[i].req; i_valid = tbl[i].valid; i_last = tbl[i].last;
      i_data = tbl[i].data; i_len = tbl[i].len; i_dst_afull = tbl[i].afull;
      edge_check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Timeout: ch0 sends one byte then goes silent; ch1 follows after GAP+IDLE.
    do_reset();
    i_req = 4'b0011;
    edge_check("to_grant", mk(4'b0001, 2'd0, 0, 8'h00, 8'h00, 0, 0));
    i_valid = 4'b0001; i_data = 32'h0000005A; i_len = 32'h00000003;
    edge_check("to_byte", mk(4'b0001, 2'd0, 1, 8'h5A, 8'h03, 0, 0));
    i_valid = 4'b0000; i_data = '0; i_len = '0;
    for (int k = 1; k < TIMEOUT; k++)
      edge_check($sformatf("to_wait[%0d]", k), mk(4'b0001, 2'd0, 0, 8'h00, 8'h03, 0, 0));
    edge_check("to_abort", mk(4'b0000, 2'd0, 0, 8'h00, 8'h03, 0, 1));
    edge_check("to_gap", mk(4'b0000, 2'd0, 0, 8'h00, 8'h03, 0, 0));
    edge_check("to_next", mk(4'b0010, 2'd1, 0, 8'h00, 8'h03, 0, 0));

    // Asynchronous reset in the middle of a ch1 packet; ch0 has priority afterwards.
    i_valid = 4'b0010; i_data = 32'h00006600; i_len = 32'h00000500;
    edge_check("rst_beat", mk(4'b0010, 2'd1, 1, 8'h66, 8'h05, 0, 0));
    i_rst_n = 1'b0;
    #1;
    check("rst_async", mk(4'b0000, 2'd0, 0, 8'h00, 8'h00, 0, 0));
    clear_inputs();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_req = 4'b0011;
    edge_check("rst_prio", mk(4'b0001, 2'd0, 0, 8'h00, 8'h00, 0, 0));

    // All four requesting, well-behaved 2-byte sources.
    do_reset();
    run_rr();

    // Randomized traffic against the model.
    do_reset();
    run_random(1500, 70, 30, 20, 2);
    run_random(1000, 20, 50, 10, 2);
    run_random(500, 95, 10, 60, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
